// File: rtl/store_commit_queue.sv
// In-order queue of committed store tags draining to the D-cache one request at a time.
// Optional macro STORE_COMMIT_FAST_ISSUE_EN: an empty, idle queue launches a request in the commit cycle.
module store_commit_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_val,
    input  logic [TAG_W-1:0]           store_id,
    output logic                       scq_rdy,
    output logic                       mem_req_val,
    output logic [TAG_W-1:0]           mem_req_id,
    input  logic                       mem_req_rdy,
    input  logic                       mem_ack,
    input  logic                       cache_stall,
    output logic                       scq_empty,
    output logic [$clog2(DEPTH+1)-1:0] scq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TAG_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // A commit while full is dropped rather than overwriting an older store.
    assign push = store_val && scq_rdy;
    assign pop  = (state == WAIT) && mem_ack;

    assign scq_rdy     = (count < FULL_COUNT);
    assign scq_count   = count;
    assign scq_empty   = (count == '0) && (state == IDLE);
    assign mem_req_val = (state == REQ);
    assign mem_req_id  = mem_req_val ? mem[head] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= store_id;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            state <= state_next;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef STORE_COMMIT_FAST_ISSUE_EN
                if ((count != '0 || push) && !cache_stall) begin
                    state_next = REQ;
                end
`else
                if (count != '0 && !cache_stall) begin
                    state_next = REQ;
                end
`endif
            end
            REQ: begin
                if (mem_req_rdy) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // The popped entry is still counted here, so one left means empty after the ack.
                if (mem_ack) begin
                    state_next = (count != ONE_COUNT && !cache_stall) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    a_no_commit_when_full: assert property (@(posedge clk) disable iff (rst)
        !(store_val && !scq_rdy));

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed self-checking bench for store_commit_queue: reset, latency, full, wrap, overlap, stall
// and mid-operation reset scenarios with hand-computed expectations.
module tb_store_commit_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef STORE_COMMIT_FAST_ISSUE_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             store_val;
    logic [TAG_W-1:0] store_id;
    logic             scq_rdy;
    logic             mem_req_val;
    logic [TAG_W-1:0] mem_req_id;
    logic             mem_req_rdy;
    logic             mem_ack;
    logic             cache_stall;
    logic             scq_empty;
    logic [CNT_W-1:0] scq_count;

    int vectors    = 0;
    int miscompares = 0;

    store_commit_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .store_val   (store_val),
        .store_id    (store_id),
        .scq_rdy     (scq_rdy),
        .mem_req_val (mem_req_val),
        .mem_req_id  (mem_req_id),
        .mem_req_rdy (mem_req_rdy),
        .mem_ack     (mem_ack),
        .cache_stall (cache_stall),
        .scq_empty   (scq_empty),
        .scq_count   (scq_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        store_val = 1'b0;
        store_id = '0;
        mem_req_rdy = 1'b0;
        mem_ack = 1'b0;
        cache_stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Accept the current request, then acknowledge it on the following cycle.
    task automatic handshake();
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (scq_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rdy got %b want 1", scq_rdy); end
        vectors++; if (scq_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty got %b want 1", scq_empty); end
        vectors++; if (scq_count !== '0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", scq_count); end
        vectors++; if (mem_req_val !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_val got %b want 0", mem_req_val); end
        vectors++; if (mem_req_id !== '0) begin miscompares++; $display("[TB] FAIL reset_id got %0d want 0", mem_req_id); end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        store_id = 6'd5;
        store_val = 1'b1;
        tick();
        store_val = 1'b0;
        vectors++; if (scq_empty !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy got %b want 0", scq_empty); end
        lat = 1;
        while (!mem_req_val && lat < 10) begin
            tick();
            lat++;
        end
        vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("[TB] FAIL single_latency got %0d want %0d", lat, EXP_LAT); end
        vectors++; if (mem_req_id !== 6'd5) begin miscompares++; $display("[TB] FAIL single_id got %0d want 5", mem_req_id); end
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        vectors++; if (mem_req_val !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wait_val got %b want 0", mem_req_val); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++; if (scq_count !== '0) begin miscompares++; $display("[TB] FAIL single_count got %0d want 0", scq_count); end
        vectors++; if (scq_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL single_empty got %b want 1", scq_empty); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            store_id = TAG_W'(10 + i);
            store_val = 1'b1;
            tick();
        end
        store_val = 1'b0;
        vectors++; if (scq_count !== CNT_W'(8)) begin miscompares++; $display("[TB] FAIL full_count got %0d want 8", scq_count); end
        vectors++; if (scq_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rdy got %b want 0", scq_rdy); end
        vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== 6'd10) begin miscompares++; $display("[TB] FAIL full_head got val=%b id=%0d want val=1 id=10", mem_req_val, mem_req_id); end
        handshake();
        vectors++; if (scq_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL full_rdy_after_pop got %b want 1", scq_rdy); end
        vectors++; if (scq_count !== CNT_W'(7)) begin miscompares++; $display("[TB] FAIL full_count_after_pop got %0d want 7", scq_count); end
        for (int k = 1; k < DEPTH; k++) begin
            vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== TAG_W'(10 + k)) begin miscompares++; $display("[TB] FAIL full_drain_%0d got val=%b id=%0d want val=1 id=%0d", k, mem_req_val, mem_req_id, 10 + k); end
            handshake();
        end
        vectors++; if (scq_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drained_empty got %b want 1", scq_empty); end
    endtask

    task automatic test_wrap();
        int got;
        int guard;
        do_reset();
        got = 0;
        guard = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int g;
                    g = 0;
                    while (!scq_rdy && g < 500) begin
                        tick();
                        g++;
                    end
                    store_id = TAG_W'(i);
                    store_val = 1'b1;
                    tick();
                    store_val = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                while (got < 20 && guard < 3000) begin
                    if (mem_req_val) begin
                        int d;
                        vectors++; if (mem_req_id !== TAG_W'(got)) begin miscompares++; $display("[TB] FAIL wrap_order got %0d want %0d", mem_req_id, got); end
                        d = $urandom_range(0, 3);
                        repeat (d) begin tick(); guard++; end
                        vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== TAG_W'(got)) begin miscompares++; $display("[TB] FAIL wrap_hold got val=%b id=%0d want val=1 id=%0d", mem_req_val, mem_req_id, got); end
                        mem_req_rdy = 1'b1;
                        tick();
                        mem_req_rdy = 1'b0;
                        d = $urandom_range(0, 3);
                        repeat (d) begin tick(); guard++; end
                        mem_ack = 1'b1;
                        tick();
                        mem_ack = 1'b0;
                        got++;
                        guard += 2;
                    end else begin
                        tick();
                        guard++;
                    end
                end
            end
        join
        vectors++; if (got !== 20) begin miscompares++; $display("[TB] FAIL wrap_issued got %0d want 20", got); end
        vectors++; if (scq_empty !== 1'b1 || scq_count !== '0) begin miscompares++; $display("[TB] FAIL wrap_final got empty=%b count=%0d want empty=1 count=0", scq_empty, scq_count); end
    endtask

    task automatic test_overlap_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            store_id = TAG_W'(30 + i);
            store_val = 1'b1;
            tick();
        end
        store_val = 1'b0;
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        mem_ack = 1'b1;
        store_val = 1'b1;
        store_id = 6'd33;
        tick();
        mem_ack = 1'b0;
        store_val = 1'b0;
        vectors++; if (scq_count !== CNT_W'(3)) begin miscompares++; $display("[TB] FAIL overlap_count got %0d want 3", scq_count); end
        vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== 6'd31) begin miscompares++; $display("[TB] FAIL overlap_next got val=%b id=%0d want val=1 id=31", mem_req_val, mem_req_id); end
        cache_stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== 6'd31) begin miscompares++; $display("[TB] FAIL stall_hold_%0d got val=%b id=%0d want val=1 id=31", c, mem_req_val, mem_req_id); end
        end
        handshake();
        vectors++; if (mem_req_val !== 1'b0 || scq_count !== CNT_W'(2)) begin miscompares++; $display("[TB] FAIL stall_block got val=%b count=%0d want val=0 count=2", mem_req_val, scq_count); end
        tick();
        vectors++; if (mem_req_val !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_idle got %b want 0", mem_req_val); end
        cache_stall = 1'b0;
        tick();
        vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== 6'd32) begin miscompares++; $display("[TB] FAIL stall_release got val=%b id=%0d want val=1 id=32", mem_req_val, mem_req_id); end
        handshake();
        vectors++; if (mem_req_val !== 1'b1 || mem_req_id !== 6'd33) begin miscompares++; $display("[TB] FAIL overlap_last got val=%b id=%0d want val=1 id=33", mem_req_val, mem_req_id); end
        handshake();
        vectors++; if (scq_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL overlap_empty got %b want 1", scq_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        store_id = 6'd40;
        store_val = 1'b1;
        tick();
        store_id = 6'd41;
        tick();
        store_val = 1'b0;
        while (!mem_req_val) tick();
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vectors++; if (scq_count !== '0) begin miscompares++; $display("[TB] FAIL midrst_count got %0d want 0", scq_count); end
        vectors++; if (mem_req_val !== 1'b0 || scq_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_idle got val=%b empty=%b want val=0 empty=1", mem_req_val, scq_empty); end
        tick();
        vectors++; if (mem_req_val !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_no_issue got %b want 0", mem_req_val); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_overlap_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
